// File: rtl/rf_wb_arbiter_pkg.sv
// rf_pkg: shared widths, requester ids and writeback request type
package rf_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: requester handshakes, flush and register file write port
interface rf_wb_arbiter_if #(parameter int XLEN = 32, parameter int REG_AW = 5);
  localparam int NUM_REGS = 2 ** REG_AW;
  logic flush;
  logic alu_valid, alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic lsu_valid, lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic RF_write;
  logic [REG_AW-1:0] Ad_C;
  logic [XLEN-1:0] C;
  logic [NUM_REGS-1:0] pend_mask;
  logic grant_id;
  modport master (
    output flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input alu_ready, lsu_ready, RF_write, Ad_C, C, pend_mask, grant_id
  );
  modport slave (
    input flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, RF_write, Ad_C, C, pend_mask, grant_id
  );
endinterface

// File: rtl/rf_wb_slot.sv
// rf_wb_slot: one-entry writeback holding register, refillable in its drain cycle
module rf_wb_slot #(parameter int XLEN = 32, parameter int REG_AW = 5) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic valid,
  input  logic drain,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [XLEN-1:0] req_data,
  output logic ready,
  output logic full,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0] data
);
  assign ready = !full || drain;
  // flush beats capture; capture beats drain so drain-and-refill keeps the slot full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      rd <= '0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (valid && ready) begin
      full <= 1'b1;
      rd <= req_rd;
      data <= req_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin sharing of the register file write port between ALU and LSU
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int REG_AW = rf_pkg::REG_AW,
  parameter logic RR_INIT = REQ_ALU
) (
  input logic clk,
  input logic rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_AW;
  logic alu_full, lsu_full, gnt, win_lsu, rr;
  logic [REG_AW-1:0] alu_rd, lsu_rd, w_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic [NUM_REGS-1:0] mask;
  rf_wb_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_alu (
    .clk(clk), .rst(rst), .flush(bus.flush), .valid(bus.alu_valid),
    .drain(gnt && !win_lsu), .req_rd(bus.alu_rd), .req_data(bus.alu_data),
    .ready(bus.alu_ready), .full(alu_full), .rd(alu_rd), .data(alu_data)
  );
  rf_wb_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_lsu (
    .clk(clk), .rst(rst), .flush(bus.flush), .valid(bus.lsu_valid),
    .drain(gnt && win_lsu), .req_rd(bus.lsu_rd), .req_data(bus.lsu_data),
    .ready(bus.lsu_ready), .full(lsu_full), .rd(lsu_rd), .data(lsu_data)
  );
  assign gnt = alu_full || lsu_full;
  assign win_lsu = lsu_full && (!alu_full || rr == REQ_LSU);
  assign w_rd = win_lsu ? lsu_rd : alu_rd;
  assign bus.RF_write = gnt && (w_rd != '0);
  assign bus.Ad_C = gnt ? w_rd : '0;
  assign bus.C = gnt ? (win_lsu ? lsu_data : alu_data) : '0;
  assign bus.grant_id = gnt && win_lsu;
  assign bus.pend_mask = mask;
  // the loser of each grant gets priority next time; idle cycles keep the pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr <= RR_INIT;
    else if (gnt) rr <= !win_lsu;
  end
  // destinations held in either slot, x0 never reported as pending
  always_comb begin
    mask = '0;
    if (alu_full) mask[alu_rd] = 1'b1;
    if (lsu_full) mask[lsu_rd] = 1'b1;
    mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus with a queued scoreboard checked by a write monitor
module tb_rf_wb_arbiter;
  import rf_pkg::*;
  typedef struct packed {
    logic gid;
    wb_req_t w;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  rf_wb_arbiter_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();
  rf_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .RR_INIT(REQ_ALU)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic exp_wr(input logic g, input logic [REG_AW-1:0] r, input logic [XLEN-1:0] d);
    q.push_back({g, r, d});
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.flush = 1'b0;
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.alu_rd = '0;
    bus.lsu_rd = '0;
    bus.alu_data = '0;
    bus.lsu_data = '0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask
  task automatic drive_alu(input logic [REG_AW-1:0] r, input logic [XLEN-1:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_rd = r;
    bus.alu_data = d;
  endtask
  task automatic drive_lsu(input logic [REG_AW-1:0] r, input logic [XLEN-1:0] d);
    bus.lsu_valid = 1'b1;
    bus.lsu_rd = r;
    bus.lsu_data = d;
  endtask
  // every register file write must match the oldest expected write
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.RF_write) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {bus.grant_id, bus.Ad_C, bus.C}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("write", {bus.grant_id, bus.Ad_C, bus.C}, e);
      end
    end
  end
  initial begin
    idle();
    #3;
    chk("rst_rf_write", bus.RF_write, 0);
    chk("rst_ad_c", bus.Ad_C, 0);
    chk("rst_c", bus.C, 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_readys", {bus.alu_ready, bus.lsu_ready}, 2'b11);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    chk("idle_rf_write", bus.RF_write, 0);
    chk("idle_grant_id", bus.grant_id, 0);
    drive_alu(3, 32'h11);
    drive_lsu(4, 32'h22);
    exp_wr(REQ_ALU, 3, 32'h11);
    exp_wr(REQ_LSU, 4, 32'h22);
    cyc();
    idle();
    #3;
    chk("sim_pend_k1", bus.pend_mask, 32'h18);
    chk("sim_readys_k1", {bus.alu_ready, bus.lsu_ready}, 2'b10);
    cyc();
    #3;
    chk("sim_pend_k2", bus.pend_mask, 32'h10);
    chk("sim_lsu_ready_k2", bus.lsu_ready, 1);
    cyc();
    chk("sim_pend_k3", bus.pend_mask, 0);
    do_reset();
    drive_alu(5, 32'hDEADBEEF);
    exp_wr(REQ_ALU, 5, 32'hDEADBEEF);
    cyc();
    idle();
    #3;
    chk("alu_pend_k1", bus.pend_mask, 32'h20);
    chk("alu_ready_k1", bus.alu_ready, 1);
    cyc();
    #3;
    chk("alu_pend_k2", bus.pend_mask, 0);
    do_reset();
    exp_wr(REQ_ALU, 6, 32'hA00);
    exp_wr(REQ_LSU, 7, 32'hB00);
    exp_wr(REQ_ALU, 6, 32'hA01);
    exp_wr(REQ_LSU, 7, 32'hB02);
    exp_wr(REQ_ALU, 6, 32'hA03);
    exp_wr(REQ_LSU, 7, 32'hB04);
    exp_wr(REQ_ALU, 6, 32'hA05);
    exp_wr(REQ_LSU, 7, 32'hB06);
    exp_wr(REQ_ALU, 6, 32'hA07);
    for (int i = 0; i <= 8; i++) begin
      drive_alu(6, 32'hA00 + i);
      drive_lsu(7, 32'hB00 + i);
      bus.alu_valid = (i < 8);
      bus.lsu_valid = (i < 8);
      if (i > 0) begin
        #3;
        chk($sformatf("rr_readys_c%0d", i), {bus.alu_ready, bus.lsu_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
      end
      cyc();
    end
    idle();
    #3;
    chk("rr_tail_ready", bus.alu_ready, 1);
    cyc();
    cyc();
    do_reset();
    drive_lsu(0, 32'h55);
    cyc();
    idle();
    #3;
    chk("x0_rf_write", bus.RF_write, 0);
    chk("x0_pend", bus.pend_mask, 0);
    chk("x0_lsu_ready", bus.lsu_ready, 1);
    chk("x0_grant_id", bus.grant_id, 1);
    cyc();
    #3;
    chk("x0_after_write", bus.RF_write, 0);
    chk("x0_after_ready", bus.lsu_ready, 1);
    do_reset();
    drive_alu(12, 32'hC0);
    drive_lsu(13, 32'hC1);
    exp_wr(REQ_ALU, 12, 32'hC0);
    cyc();
    idle();
    bus.flush = 1'b1;
    drive_alu(14, 32'hEE);
    #3;
    chk("fl_pend_j", bus.pend_mask, 32'h3000);
    chk("fl_readys_j", {bus.alu_ready, bus.lsu_ready}, 2'b10);
    cyc();
    idle();
    #3;
    chk("fl_pend_j1", bus.pend_mask, 0);
    chk("fl_readys_j1", {bus.alu_ready, bus.lsu_ready}, 2'b11);
    chk("fl_write_j1", bus.RF_write, 0);
    cyc();
    drive_alu(21, 32'hA1);
    drive_lsu(20, 32'hB1);
    exp_wr(REQ_LSU, 20, 32'hB1);
    exp_wr(REQ_ALU, 21, 32'hA1);
    cyc();
    idle();
    cyc();
    cyc();
    drive_alu(8, 32'h77);
    cyc();
    idle();
    #1;
    rst = 1'b1;
    #2;
    chk("mid_rst_write", bus.RF_write, 0);
    chk("mid_rst_pend", bus.pend_mask, 0);
    chk("mid_rst_ready", bus.alu_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    cyc();
    chk("mid_rst_after", bus.pend_mask, 0);
    repeat (3) cyc();
    chk("pending_writes", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
